// File: rtl/mem_arbiter.sv
// Round-robin fetch/load-store arbiter in front of the byte-serial memory unit.
// Define ARB_DATA_PRIORITY_EN to give the load/store port fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              ls_valid,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_len,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              mu_valid,
  output logic              mu_wr,
  output logic [ADDR_W-1:0] mu_addr,
  output logic [2:0]        mu_len,
  output logic [31:0]       mu_wdata,
  input  logic [31:0]       mu_rdata,
  input  logic              mu_ready,
  output logic              mu_clear
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                own_ls_q, own_ls_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          len_q, len_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         ls_data_q, ls_data_d;
  logic                grant_if, grant_ls;
  logic                kill;
  logic                active;

`ifdef ARB_DATA_PRIORITY_EN
  assign grant_ls = ls_valid;
`else
  logic last_ls_q, last_ls_d;
  assign grant_ls = ls_valid && (!if_valid || !last_ls_q);
`endif
  assign grant_if = if_valid && !grant_ls;

  // A flush kills loads and fetches only; an issued store must finish.
  assign kill   = rob_clear && !wr_q;
  assign active = (state_q == S_BUSY) || (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    own_ls_d  = own_ls_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    ls_data_d = ls_data_q;
`ifndef ARB_DATA_PRIORITY_EN
    last_ls_d = last_ls_q;
`endif
    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rob_clear && (grant_if || grant_ls)) begin
            state_d  = S_BUSY;
            own_ls_d = grant_ls;
            wr_d     = grant_ls && ls_wr;
            addr_d   = grant_ls ? ls_addr : if_addr;
            len_d    = grant_ls ? ls_len : 3'b010;
            wdata_d  = grant_ls ? ls_wdata : 32'h0;
`ifndef ARB_DATA_PRIORITY_EN
            last_ls_d = grant_ls;
`endif
          end
        end
        S_BUSY: begin
          if (kill) begin
            state_d = S_IDLE;
          end else if (mu_ready) begin
            state_d = S_DONE;
            if (own_ls_q) ls_data_d = wr_q ? 32'h0 : mu_rdata;
            else          if_data_d = mu_rdata;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      own_ls_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= 3'b000;
      wdata_q   <= 32'h0;
      if_data_q <= 32'h0;
      ls_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      own_ls_q  <= own_ls_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      ls_data_q <= ls_data_d;
    end
  end

`ifndef ARB_DATA_PRIORITY_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) last_ls_q <= 1'b1;
    else        last_ls_q <= last_ls_d;
  end
`endif

  assign mu_valid = (state_q == S_BUSY) && !mu_ready;
  assign mu_wr    = wr_q;
  assign mu_addr  = addr_q;
  assign mu_len   = len_q;
  assign mu_wdata = wdata_q;
  assign mu_clear = rob_clear && !(active && wr_q);

  assign if_ready = (state_q == S_DONE) && !own_ls_q && !(rdy_in && kill);
  assign ls_ready = (state_q == S_DONE) && own_ls_q && !(rdy_in && kill);
  assign if_data  = if_data_q;
  assign ls_rdata = ls_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, corner sequences and random traffic
// against a transaction-level model with an emulated memory unit.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, rob_clear;
  logic        if_valid, if_ready, ls_valid, ls_wr, ls_ready;
  logic        mu_valid, mu_wr, mu_ready, mu_clear;
  logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
  logic [31:0] mu_addr, mu_wdata, mu_rdata;
  logic [2:0]  ls_len, mu_len;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_data(if_data), .ls_valid(ls_valid), .ls_wr(ls_wr),
    .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata), .mu_valid(mu_valid),
    .mu_wr(mu_wr), .mu_addr(mu_addr), .mu_len(mu_len),
    .mu_wdata(mu_wdata), .mu_rdata(mu_rdata), .mu_ready(mu_ready),
    .mu_clear(mu_clear)
  );

  typedef struct {
    bit          ls;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  bit          in_txn, exp_done, own_ls, last_ls_m, prev_if_v, prev_ls_v;
  bit          s_wr, force_en, rnd_lat;
  logic [2:0]  s_len;
  logic [31:0] s_addr, s_wdata, exp_data, force_val;
  int          resp_cnt, resp_lat, n_starts;

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic mdl_reset();
    in_txn = 0; exp_done = 0; resp_cnt = 0; last_ls_m = 1;
    prev_if_v = 0; prev_ls_v = 0; mu_ready = 1'b0;
  endtask

  // One cycle of memory-unit emulation and checking, called at a negedge
  // after the requesters have driven their inputs.
  task automatic ev();
    bit          st_phase, abort, done_n, e_if, e_ls;
    logic [31:0] rd;
    done_n = 0;
    mu_ready = 1'b0;
    mu_rdata = $urandom;
    #1;
    if (mu_valid && !in_txn) begin
      n_starts++;
      in_txn = 1;
      resp_cnt = 0;
`ifdef ARB_DATA_PRIORITY_EN
      own_ls = prev_ls_v;
`else
      own_ls = prev_ls_v && (!prev_if_v || !last_ls_m);
`endif
      last_ls_m = own_ls;
      if (own_ls) begin
        s_wr = ls_wr; s_len = ls_len; s_addr = ls_addr; s_wdata = ls_wdata;
        chk("grant_wdata", mu_wdata, s_wdata);
      end else begin
        s_wr = 0; s_len = 3'b010; s_addr = if_addr; s_wdata = mu_wdata;
      end
      chk("grant_req", {mu_wr, mu_len, mu_addr}, {s_wr, s_len, s_addr});
    end
    if (in_txn)
      chk("mu_stable", {mu_valid, mu_wr, mu_len, mu_addr, mu_wdata},
          {1'b1, s_wr, s_len, s_addr, s_wdata});
    st_phase = (in_txn || exp_done) && s_wr;
    if (in_txn && rdy_in) begin
      resp_cnt++;
      if (resp_cnt >= resp_lat) begin
        rd = force_en ? force_val : mem_fn(mu_addr);
        mu_ready = 1'b1;
        mu_rdata = rd;
        in_txn = 0;
        if (!(rob_clear && !s_wr)) begin
          done_n = 1;
          exp_data = s_wr ? 32'h0 : rd;
        end
        if (rnd_lat) resp_lat = $urandom_range(1, 4);
      end
    end
    if (in_txn && rdy_in && rob_clear && !s_wr) in_txn = 0;
    #1;
    abort = rdy_in && rob_clear && !s_wr;
    e_if = exp_done && !own_ls && !abort;
    e_ls = exp_done && own_ls && !abort;
    chk("if_ready", if_ready, e_if);
    chk("ls_ready", ls_ready, e_ls);
    if (e_if) chk("if_data", if_data, exp_data);
    if (e_ls) chk("ls_rdata", ls_rdata, exp_data);
    chk("mu_clear", mu_clear, rob_clear && !st_phase);
    if (rdy_in) exp_done = 0;
    if (done_n) exp_done = 1;
    prev_if_v = if_valid;
    prev_ls_v = ls_valid;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ev();
    end
  endtask

  task automatic do_reset();
    rst_in = 1; rdy_in = 1; rob_clear = 0; if_valid = 0; ls_valid = 0;
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", {if_ready, ls_ready, mu_valid, mu_wr, mu_clear, mu_len}, 0);
    chk("reset_data", {if_data, ls_rdata, mu_addr}, 0);
    chk("reset_wdata", mu_wdata, 0);
    rst_in = 0;
  endtask

  task automatic set_ls(bit wr, logic [31:0] a, logic [2:0] l, logic [31:0] d);
    ls_valid = 1; ls_wr = wr; ls_addr = a; ls_len = l; ls_wdata = d;
  endtask

  task automatic run_vec(vec_t v);
    int          st, got;
    logic [31:0] d;
    st = n_starts; got = -1; d = 32'h0;
    force_en = 1; force_val = v.rdata; resp_lat = v.lat; rnd_lat = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (v.ls) set_ls(v.wr, v.addr, v.len, v.wdata);
        else begin if_valid = 1; if_addr = v.addr; end
      end
      if (got >= 0) begin if_valid = 0; ls_valid = 0; end
      ev();
      if (got < 0 && (v.ls ? ls_ready : if_ready)) begin
        got = c;
        d = v.ls ? ls_rdata : if_data;
      end
    end
    chk("vec_cycle", got, v.exp_cyc);
    chk("vec_data", d, v.exp_data);
    chk("vec_one_txn", n_starts - st, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    vec_t    tbl[7];
    bit      ord[$];
    bit      exp_ord[4];
    bit      if_done, ls_done;
    int      st, got, n_comp;

    if_addr = 0; ls_wr = 0; ls_addr = 0; ls_len = 0; ls_wdata = 0;
    mu_ready = 0; mu_rdata = 0; n_starts = 0; force_en = 0;
    force_val = 0; rnd_lat = 0; resp_lat = 2; exp_data = 0;
    s_wr = 0; s_len = 0; s_addr = 0; s_wdata = 0; own_ls = 0;
    do_reset();

    tbl[0] = '{0, 0, 32'h100,      3'b010, 0,            4, 32'hDEADBEEF, 32'hDEADBEEF, 5};
    tbl[1] = '{1, 0, 32'h20,       3'b000, 0,            2, 32'h000000AB, 32'h000000AB, 3};
    tbl[2] = '{1, 1, 32'h30,       3'b010, 32'h12345678, 3, 32'hFFFFFFFF, 32'h0,        4};
    tbl[3] = '{1, 0, 32'h42,       3'b101, 0,            1, 32'h0000BEEF, 32'h0000BEEF, 2};
    tbl[4] = '{0, 0, 32'hFFFFFFFC, 3'b010, 0,            1, 32'h00000013, 32'h00000013, 2};
    tbl[5] = '{1, 1, 32'h7,        3'b000, 32'hA5,       5, 32'h11111111, 32'h0,        6};
    tbl[6] = '{1, 0, 32'h1000,     3'b001, 0,            3, 32'hFFFF8001, 32'hFFFF8001, 4};
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // contention straight out of reset
    do_reset();
`ifdef ARB_DATA_PRIORITY_EN
    exp_ord = '{1, 1, 1, 1};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    force_en = 0; resp_lat = 2;
    if_addr = 32'h200;
    if_valid = 1;
    set_ls(0, 32'h20, 3'b000, 0);
    for (int c = 0; c < 40 && ord.size() < 4; c++) begin
      @(negedge clk);
      ev();
      if (if_ready) ord.push_back(1'b0);
      if (ls_ready) ord.push_back(1'b1);
    end
    @(negedge clk);
    if_valid = 0; ls_valid = 0;
    ev();
    chk("contention_count", ord.size(), 4);
    for (int i = 0; i < 4 && i < ord.size(); i++)
      chk("contention_order", ord[i], exp_ord[i]);
    idle(3);

    // store survives rob_clear in BUSY and DONE
    force_en = 1; force_val = 32'hCAFEF00D; resp_lat = 4;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) set_ls(1, 32'h30, 3'b010, 32'h12345678);
      if (c == 6) ls_valid = 0;
      rob_clear = (c == 2 || c == 5);
      ev();
      if (c == 2) chk("store_clear_busy", {mu_clear, mu_valid, mu_addr}, {2'b01, 32'h30});
      if (c == 5) chk("store_done", {ls_ready, mu_clear, ls_rdata}, {2'b10, 32'h0});
    end
    rob_clear = 0;

    // load aborted in BUSY, then re-granted
    st = n_starts; got = -1; resp_lat = 3; force_val = 32'h0BADCAFE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) set_ls(0, 32'h44, 3'b010, 0);
      if (got >= 0) ls_valid = 0;
      rob_clear = (c == 2);
      ev();
      if (c == 2) chk("abort_clear", mu_clear, 1);
      if (c == 3) chk("abort_idle", mu_valid, 0);
      if (c == 4) chk("abort_regrant", mu_valid, 1);
      if (got < 0 && ls_ready) got = c;
    end
    chk("abort_ready_cycle", got, 7);
    chk("abort_txns", n_starts - st, 2);
    rob_clear = 0;

    // rob_clear in IDLE blocks the grant; in DONE it kills a fetch
    st = n_starts; got = -1; resp_lat = 1; force_val = 32'h00C0FFEE;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin if_valid = 1; if_addr = 32'h300; end
      if (got >= 0) if_valid = 0;
      rob_clear = (c == 0 || c == 3);
      ev();
      if (c == 0) chk("idle_clear", mu_clear, 1);
      if (c == 2) chk("idle_no_grant", n_starts - st, 1);
      if (c == 3) chk("done_kill", {if_ready, mu_clear}, 2'b01);
      if (got < 0 && if_ready) got = c;
    end
    chk("done_kill_retry_cycle", got, 6);
    rob_clear = 0;

    // rdy_in low for three BUSY cycles
    got = -1; resp_lat = 3; force_val = 32'h600DF00D;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) set_ls(0, 32'h50, 3'b010, 0);
      if (got >= 0) ls_valid = 0;
      rdy_in = !(c >= 2 && c <= 4);
      ev();
      if (c == 3) chk("freeze_hold", {mu_valid, mu_addr}, {1'b1, 32'h50});
      if (got < 0 && ls_ready && rdy_in) got = c;
    end
    chk("freeze_shift", got, 7);
    rdy_in = 1;

    // async reset between edges, in BUSY and in DONE
    resp_lat = 5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin if_valid = 1; if_addr = 32'h400; end
      ev();
    end
    #1 rst_in = 1;
    #1;
    chk("arst_busy", {mu_valid, if_ready, ls_ready}, 0);
    mdl_reset();
    @(negedge clk);
    rst_in = 0;
    if_valid = 0;
    ev();
    chk("arst_idle", mu_valid, 0);
    idle(2);
    resp_lat = 1; force_val = 32'h77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) set_ls(0, 32'h60, 3'b000, 0);
      ev();
    end
    chk("pre_arst_done", ls_ready, 1);
    #1 rst_in = 1;
    #1;
    chk("arst_done", {ls_ready, ls_rdata}, 0);
    mdl_reset();
    @(negedge clk);
    rst_in = 0;
    ls_valid = 0;
    idle(2);

    // random traffic
    do_reset();
    force_en = 0; rnd_lat = 1; resp_lat = 2;
    if_done = 0; ls_done = 0; n_comp = 0;
    for (int c = 0; c < 3200; c++) begin
      @(negedge clk);
      if (if_done) begin if_valid = 0; if_done = 0; n_comp++; end
      if (ls_done) begin ls_valid = 0; ls_done = 0; n_comp++; end
      if (c < 3000) begin
        if (!if_valid && $urandom_range(0, 2) == 0) begin
          if_valid = 1; if_addr = $urandom & 32'hFFFFFFFC;
        end
        if (!ls_valid && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 4))
            0: ls_len = 3'b000;
            1: ls_len = 3'b001;
            2: ls_len = 3'b010;
            3: ls_len = 3'b100;
            default: ls_len = 3'b101;
          endcase
          set_ls($urandom_range(0, 1), $urandom, ls_len, $urandom);
        end
        rdy_in = $urandom_range(0, 9) != 0;
        rob_clear = $urandom_range(0, 19) == 0;
      end else begin
        rdy_in = 1; rob_clear = 0;
      end
      ev();
      if (if_ready && rdy_in) if_done = 1;
      if (ls_ready && rdy_in) ls_done = 1;
    end
    @(negedge clk);
    if (if_done) begin if_valid = 0; n_comp++; end
    if (ls_done) begin ls_valid = 0; n_comp++; end
    ev();
    chk("rand_drained", {if_valid, ls_valid}, 0);
    chk("rand_progress", n_comp > 300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
